triple_buffer_controller: RTL and testbench

- Triple-buffer index allocator for the SDRAM frame buffer; runs in the frame-buffer clock domain.
- Hands out 2-bit buffer indices (0..2) to one writer (camera path) and one reader (display path) over a shared id/valid output.
- Guarantees the writer never gets the buffer the reader holds.
- The reader always gets the most recently completed frame.

---
 rtl/triple_buffer_controller.sv | 144 ++++++++++++++
 tb/tb_triple_buffer_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/triple_buffer_controller.sv
// Triple-buffer index allocator: one writer and one reader share a grant output; the writer never receives the buffer the reader holds.
// Optional simulation logging is compiled only when BUFFER_CONTROLLER_LOG_EN is defined.
module triple_buffer_controller #(
    parameter int LOG_LEVEL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       write_rq_rdy,
    input  logic       finalize_wr,
    input  logic       read_rq_rdy,
    input  logic       finalize_rd,
    output logic       buffer_id_valid,
    output logic [1:0] buffer_id
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_GRANT = 2'd1,
        RD_GRANT = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] last_written_reg, last_written_next;
    logic [1:0] wr_buf_reg, wr_buf_next;
    logic       wr_busy_reg, wr_busy_next;
    logic [1:0] rd_buf_reg, rd_buf_next;
    logic       rd_busy_reg, rd_busy_next;
    logic [1:0] buffer_id_reg, buffer_id_next;
    logic       buffer_id_valid_reg, buffer_id_valid_next;

    logic [1:0] wr_n1, wr_n2, wr_pick;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Prefer the buffer after the newest frame; step once more if the reader holds it.
    always_comb begin
        wr_n1   = mod3_inc(last_written_reg);
        wr_n2   = mod3_inc(wr_n1);
        wr_pick = (rd_busy_reg && (wr_n1 == rd_buf_reg)) ? wr_n2 : wr_n1;
    end

    always_comb begin
        state_next           = state_reg;
        last_written_next    = last_written_reg;
        wr_buf_next          = wr_buf_reg;
        wr_busy_next         = wr_busy_reg;
        rd_buf_next          = rd_buf_reg;
        rd_busy_next         = rd_busy_reg;
        buffer_id_next       = buffer_id_reg;
        buffer_id_valid_next = buffer_id_valid_reg;

        if (finalize_wr && wr_busy_reg) begin
            last_written_next = wr_buf_reg;
            wr_busy_next      = 1'b0;
        end
        if (finalize_rd && rd_busy_reg) begin
            rd_busy_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (write_rq_rdy && !wr_busy_reg) begin
                    wr_buf_next          = wr_pick;
                    wr_busy_next         = 1'b1;
                    buffer_id_next       = wr_pick;
                    buffer_id_valid_next = 1'b1;
                    state_next           = WR_GRANT;
                end else if (read_rq_rdy && !rd_busy_reg) begin
                    // Uses the pre-update frame even if finalize_wr lands on this edge.
                    rd_buf_next          = last_written_reg;
                    rd_busy_next         = 1'b1;
                    buffer_id_next       = last_written_reg;
                    buffer_id_valid_next = 1'b1;
                    state_next           = RD_GRANT;
                end
            end
            WR_GRANT: begin
                if (!write_rq_rdy) begin
                    buffer_id_valid_next = 1'b0;
                    state_next           = IDLE;
                end
            end
            RD_GRANT: begin
                if (!read_rq_rdy) begin
                    buffer_id_valid_next = 1'b0;
                    state_next           = IDLE;
                end
            end
            default: begin
                buffer_id_valid_next = 1'b0;
                state_next           = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg           <= IDLE;
            last_written_reg    <= 2'd0;
            wr_buf_reg          <= 2'd0;
            wr_busy_reg         <= 1'b0;
            rd_buf_reg          <= 2'd0;
            rd_busy_reg         <= 1'b0;
            buffer_id_reg       <= 2'd0;
            buffer_id_valid_reg <= 1'b0;
        end else begin
            state_reg           <= state_next;
            last_written_reg    <= last_written_next;
            wr_buf_reg          <= wr_buf_next;
            wr_busy_reg         <= wr_busy_next;
            rd_buf_reg          <= rd_buf_next;
            rd_busy_reg         <= rd_busy_next;
            buffer_id_reg       <= buffer_id_next;
            buffer_id_valid_reg <= buffer_id_valid_next;
        end
    end

    assign buffer_id       = buffer_id_reg;
    assign buffer_id_valid = buffer_id_valid_reg;

`ifdef BUFFER_CONTROLLER_LOG_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && (LOG_LEVEL > 0)) begin
            if (state_reg == IDLE && state_next == WR_GRANT)
                $display("%t %m: write grant buffer %0d", $time, wr_pick);
            if (state_reg == IDLE && state_next == RD_GRANT)
                $display("%t %m: read grant buffer %0d", $time, last_written_reg);
            if (finalize_wr)
                $display("%t %m: finalize_wr %s", $time, wr_busy_reg ? "applied" : "ignored");
            if (finalize_rd)
                $display("%t %m: finalize_rd %s", $time, rd_busy_reg ? "applied" : "ignored");
            if ((LOG_LEVEL > 1) && state_reg == IDLE && write_rq_rdy && wr_busy_reg)
                $display("%t %m: write request waiting for finalize", $time);
            if ((LOG_LEVEL > 1) && state_reg == IDLE && read_rq_rdy && rd_busy_reg && !write_rq_rdy)
                $display("%t %m: read request waiting for finalize", $time);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_triple_buffer_controller.sv
// Directed and randomized bench for triple_buffer_controller, checked against a buffer-ownership model.
module tb_triple_buffer_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       write_rq_rdy = 1'b0;
    logic       finalize_wr = 1'b0;
    logic       read_rq_rdy = 1'b0;
    logic       finalize_rd = 1'b0;
    logic       buffer_id_valid;
    logic [1:0] buffer_id;

    int n_checks = 0;
    int n_fail = 0;

    // Model: who owns which buffer and which frame is newest.
    int m_last, m_wr_buf, m_rd_buf;
    bit m_wr_busy, m_rd_busy;

    triple_buffer_controller dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .write_rq_rdy    (write_rq_rdy),
        .finalize_wr     (finalize_wr),
        .read_rq_rdy     (read_rq_rdy),
        .finalize_rd     (finalize_rd),
        .buffer_id_valid (buffer_id_valid),
        .buffer_id       (buffer_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_wr_id();
        // First buffer after the newest frame that the reader does not hold.
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (!(m_rd_busy && c == m_rd_buf)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 0; m_wr_buf = 0; m_rd_buf = 0; m_wr_busy = 0; m_rd_busy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        write_rq_rdy = 1'b0; read_rq_rdy = 1'b0; finalize_wr = 1'b0; finalize_rd = 1'b0;
        #1 check("reset_valid", buffer_id_valid, 0);
        check("reset_id", buffer_id, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic write_req(input string tag, input int hold, output int id);
        int lat;
        int e;
        e = exp_wr_id();
        @(negedge clk);
        write_rq_rdy = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!buffer_id_valid && lat < 20);
        check({tag, "_wlat"}, lat, 1);
        check({tag, "_wid"}, buffer_id, e);
        id = buffer_id;
        m_wr_buf = e; m_wr_busy = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_whold"}, buffer_id_valid, 1);
        end
        write_rq_rdy = 1'b0;
        @(negedge clk);
        check({tag, "_wdrop"}, buffer_id_valid, 0);
        check({tag, "_wkeep"}, buffer_id, e);
        $display("write grant %s: id=%0d last_written=%0d", tag, id, m_last);
    endtask

    task automatic read_req(input string tag, input int hold, output int id);
        int lat;
        @(negedge clk);
        read_rq_rdy = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!buffer_id_valid && lat < 20);
        check({tag, "_rlat"}, lat, 1);
        check({tag, "_rid"}, buffer_id, m_last);
        id = buffer_id;
        m_rd_buf = m_last; m_rd_busy = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_rhold"}, buffer_id_valid, 1);
        end
        read_rq_rdy = 1'b0;
        @(negedge clk);
        check({tag, "_rdrop"}, buffer_id_valid, 0);
        $display("read grant %s: id=%0d", tag, id);
    endtask

    task automatic fin(input bit w, input bit r);
        @(negedge clk);
        finalize_wr = w; finalize_rd = r;
        if (w && m_wr_busy) begin m_last = m_wr_buf; m_wr_busy = 0; end
        if (r && m_rd_busy) m_rd_busy = 0;
        @(negedge clk);
        finalize_wr = 1'b0; finalize_rd = 1'b0;
        check("fin_no_grant", buffer_id_valid, 0);
        $display("finalize wr=%0d rd=%0d: last_written=%0d", w, r, m_last);
    endtask

    initial begin
        int id, e, lat;
        model_reset();
        #1 check("por_valid", buffer_id_valid, 0);
        check("por_id", buffer_id, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: writes only cycle 1,2,0,...
        for (int i = 0; i < 10; i++) begin
            write_req("p1", 0, id);
            check("p1_seq", id, (i + 1) % 3);
            fin(1, 0);
        end

        // 2: reader lock forces the writer to skip
        do_reset();
        for (int i = 0; i < 3; i++) begin write_req("p2w", 0, id); fin(1, 0); end
        read_req("p2r", 1, id);
        check("p2_rd0", id, 0);
        write_req("p2a", 0, id); check("p2_w1", id, 1); fin(1, 0);
        write_req("p2b", 0, id); check("p2_w2", id, 2); fin(1, 0);
        write_req("p2c", 1, id); check("p2_skip", id, 1); fin(1, 0);
        fin(0, 1);
        write_req("p2d", 0, id); check("p2_w2b", id, 2); fin(1, 0);

        // 3: simultaneous requests, write first
        do_reset();
        @(negedge clk);
        write_rq_rdy = 1'b1; read_rq_rdy = 1'b1;
        @(negedge clk);
        check("p3_wvalid", buffer_id_valid, 1);
        check("p3_wid", buffer_id, 1);
        m_wr_buf = 1; m_wr_busy = 1;
        write_rq_rdy = 1'b0;
        @(negedge clk);
        check("p3_gap", buffer_id_valid, 0);
        @(negedge clk);
        check("p3_rvalid", buffer_id_valid, 1);
        check("p3_rid", buffer_id, 0);
        m_rd_buf = 0; m_rd_busy = 1;
        read_rq_rdy = 1'b0;
        @(negedge clk);
        check("p3_rdrop", buffer_id_valid, 0);
        $display("simultaneous: write id=1 then read id=0");
        fin(1, 1);

        // 4: spurious finalize pulses
        fin(1, 0); fin(0, 1); fin(1, 1);
        write_req("p4", 0, id);
        check("p4_id", id, 2);
        fin(1, 0);

        // 5: second write before finalize waits
        write_req("p5a", 0, id);
        @(negedge clk);
        write_rq_rdy = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("p5_wait", buffer_id_valid, 0);
        end
        finalize_wr = 1'b1;
        m_last = m_wr_buf; m_wr_busy = 0;
        @(negedge clk);
        finalize_wr = 1'b0;
        check("p5_fin_edge", buffer_id_valid, 0);
        e = exp_wr_id();
        @(negedge clk);
        check("p5_valid", buffer_id_valid, 1);
        check("p5_id", buffer_id, e);
        m_wr_buf = e; m_wr_busy = 1;
        write_rq_rdy = 1'b0;
        @(negedge clk);
        check("p5_drop", buffer_id_valid, 0);
        $display("write after finalize: id=%0d", e);
        fin(1, 0);

        // 6: reset while writer holds buffer 2
        do_reset();
        write_req("p6a", 0, id); fin(1, 0);
        @(negedge clk);
        write_rq_rdy = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!buffer_id_valid && lat < 20);
        check("p6_hold_id", buffer_id, 2);
        #2 reset_n = 1'b0;
        #1 check("p6_async_valid", buffer_id_valid, 0);
        write_rq_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        write_req("p6b", 0, id);
        check("p6_after", id, 1);
        fin(1, 0);

        // Randomized traffic against the ownership model
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0, 1: if (!m_wr_busy) write_req("rnd", $urandom_range(0, 3), id); else fin(1, 0);
                2:    if (!m_rd_busy) read_req("rnd", $urandom_range(0, 3), id); else fin(0, 1);
                3:    fin(1, 0);
                4:    fin(0, 1);
                default: fin(1, 1);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
